vc_wrr_scheduler: RTL



---
 rtl/vc_wrr_scheduler_if.sv | 37 +++
 rtl/vc_wrr_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/vc_wrr_scheduler_if.sv
// vc_wrr_scheduler_if: VC FIFO read side and D FIFO write side of the WRR scheduler.
// master = scheduler view, slave = FIFO/environment view.
`default_nettype none

interface vc_wrr_scheduler_if #(
  parameter int DATA_W = 6
);
  logic              VC0_empty;
  logic              VC1_empty;
  logic [DATA_W-1:0] data_VC0;
  logic [DATA_W-1:0] data_VC1;
  logic              VC0_pop;
  logic              VC1_pop;
  logic              D0_full;
  logic              D0_almost_full;
  logic              D1_full;
  logic              D1_almost_full;
  logic              D0_push;
  logic              D1_push;
  logic [DATA_W-1:0] data_out;
  logic              active_vc;
  logic              overflow_err;

  modport master (
    input  VC0_empty, VC1_empty, data_VC0, data_VC1,
    input  D0_full, D0_almost_full, D1_full, D1_almost_full,
    output VC0_pop, VC1_pop, D0_push, D1_push, data_out, active_vc, overflow_err
  );

  modport slave (
    output VC0_empty, VC1_empty, data_VC0, data_VC1,
    output D0_full, D0_almost_full, D1_full, D1_almost_full,
    input  VC0_pop, VC1_pop, D0_push, D1_push, data_out, active_vc, overflow_err
  );
endinterface

`default_nettype wire

// File: rtl/vc_wrr_scheduler.sv
// vc_wrr_scheduler: weighted round-robin pop of VC0/VC1, one-cycle read realignment,
// routing of each word to D0 or D1 by its DEST_BIT.
`default_nettype none

module vc_wrr_scheduler #(
  parameter int DATA_W   = 6,
  parameter int DEST_BIT = 4,
  parameter int W0       = 3,
  parameter int W1       = 1
) (
  input  logic                clk,
  input  logic                reset_L,
  vc_wrr_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  localparam logic [3:0] W0_C = 4'(W0);
  localparam logic [3:0] W1_C = 4'(W1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [3:0]        cnt_inc;
  logic [3:0]        w_sel;
  logic              pause;
  logic              owner;
  logic              sel_valid;
  logic              sel_vc;
  logic              pop_any;
  logic              pop_d0;
  logic              pop_d1;
  logic              d0_push;
  logic              d1_push;
  logic              err;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] data_out;

  assign pause = bus.D0_full | bus.D0_almost_full | bus.D1_full | bus.D1_almost_full;
  assign owner = (state == SERVE1);

  // Owner first; fall over to the other VC in the same cycle so an empty owner costs no bubble.
  always_comb begin
    sel_valid = 1'b0;
    sel_vc    = 1'b0;
    if (!owner) begin
      if (!bus.VC0_empty) begin
        sel_valid = 1'b1;
        sel_vc    = 1'b0;
      end else if (!bus.VC1_empty) begin
        sel_valid = 1'b1;
        sel_vc    = 1'b1;
      end
    end else begin
      if (!bus.VC1_empty) begin
        sel_valid = 1'b1;
        sel_vc    = 1'b1;
      end else if (!bus.VC0_empty) begin
        sel_valid = 1'b1;
        sel_vc    = 1'b0;
      end
    end
  end

  assign pop_any     = reset_L & ~pause & sel_valid;
  assign bus.VC0_pop = pop_any & ~sel_vc;
  assign bus.VC1_pop = pop_any & sel_vc;

  assign cnt_inc = cnt + 4'd1;
  assign w_sel   = sel_vc ? W1_C : W0_C;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (pop_any) begin
      if (sel_vc == owner) begin
        if (cnt_inc == w_sel) begin
          state_nxt = sel_vc ? SERVE0 : SERVE1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end else if (w_sel == 4'd1) begin
        // Borrowed turn already exhausted by this single pop.
        state_nxt = sel_vc ? SERVE0 : SERVE1;
        cnt_nxt   = 4'd0;
      end else begin
        state_nxt = sel_vc ? SERVE1 : SERVE0;
        cnt_nxt   = 4'd1;
      end
    end else if (!pause && bus.VC0_empty && bus.VC1_empty) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  assign word = pop_d1 ? bus.data_VC1 : bus.data_VC0;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      pop_d0   <= 1'b0;
      pop_d1   <= 1'b0;
      d0_push  <= 1'b0;
      d1_push  <= 1'b0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pop_d0 <= bus.VC0_pop;
      pop_d1 <= bus.VC1_pop;
      if (pop_d0 | pop_d1) begin
        data_out <= word;
        d0_push  <= ~word[DEST_BIT];
        d1_push  <= word[DEST_BIT];
      end else begin
        d0_push <= 1'b0;
        d1_push <= 1'b0;
      end
      if ((d0_push & bus.D0_full) | (d1_push & bus.D1_full))
        err <= 1'b1;
    end
  end

  assign bus.D0_push      = d0_push;
  assign bus.D1_push      = d1_push;
  assign bus.data_out     = data_out;
  assign bus.active_vc    = owner;
  assign bus.overflow_err = err;

endmodule

`default_nettype wire
